ps2_move_decoder: RTL
=====================

PS2_MOVE_DECODER -- requirements
Module: ps2_move_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning idle cycles after which a pending prefix is discarded (20 ms at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue entries; fixed power of two.
REQ-003 clk  in  1  single clock (clk_100mhz domain); all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 byte_in  in  8  received PS/2 scan-code byte from the PS2 receiver.
REQ-006 byte_valid  in  1  one-cycle strobe qualifying byte_in.
REQ-007 rd_en  in  1  one-cycle pop strobe from MIO_BUS when the CPU reads the key port.
REQ-008 key_out  out  10  {valid, overflow, 5'b0, dir[2:0]}; drives the bus key word.
REQ-009 count  out  3  current queue occupancy, 0..4.

Function
REQ-010 Direction codes SHALL be: 1 up, 2 down, 3 left, 4 right, 5 restart; 0 means none.
REQ-011 Parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK.
REQ-012 IDLE + byte: E0 -> EXT; F0 -> BRK; else decode as non-extended make, stay IDLE.
REQ-013 EXT + byte: F0 -> EXT_BRK; else decode as extended make, go IDLE.
REQ-014 BRK / EXT_BRK + byte: decode as non-extended / extended break, go IDLE; never push.
REQ-015 Extended map: 75 up, 72 down, 6B left, 74 right. Non-extended map: 5A (Enter) and 2D (R) restart. All other codes ignored, with no push and no error.
REQ-016 Each mapped code SHALL own a held bit (5 bits). A make with its held bit clear SHALL push and set the bit. A make with its held bit set SHALL be suppressed (typematic repeat). A break of the code SHALL clear the bit.
REQ-017 Push latency: key_out valid/dir SHALL reflect a push into an empty queue in the cycle after the byte_valid edge.
REQ-018 key_out[9] SHALL be 1 iff count != 0. key_out[2:0] SHALL be the head entry, or 0 when empty.
REQ-019 rd_en with count != 0 SHALL pop the head; rd_en when empty SHALL be ignored.
REQ-020 Push when full without simultaneous pop SHALL drop the event and set overflow (key_out[8]).
REQ-021 Push and pop in the same cycle when full SHALL perform both, keep count at 4, and not set overflow.
REQ-022 Push and pop in the same cycle when empty SHALL perform the push only; count becomes 1.
REQ-023 overflow SHALL be sticky and cleared only by a successful pop or by reset.
REQ-024 The timeout counter SHALL run in any non-IDLE state and restart on every byte_valid. On reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE with no push and no held-bit change.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.

Reset
REQ-026 On rst: FSM IDLE, queue empty, pointers 0, held bits 0, overflow 0, timeout counter 0, key_out 10'h000, count 0.
REQ-027 rst SHALL dominate byte_valid and rd_en in the same cycle. A prefix in progress SHALL be discarded, and a following byte SHALL be parsed from IDLE.

Configuration
REQ-028 Macro PS2_WASD_EN, when defined, SHALL add a non-extended map: 1D (W) up, 1B (S) down, 1C (A) left, 23 (D) right. These keys SHALL have their own held bits (9 total).
REQ-029 Without PS2_WASD_EN, codes 1D/1B/1C/23 SHALL be ignored like any unmapped code.

Verification
REQ-030 Bytes E0,75 -> next cycle key_out=10'h201, count=1; rd_en -> key_out=10'h000, count=0.
REQ-031 Bytes E0,6B,E0,6B,E0,6B,E0,F0,6B,E0,6B -> exactly two left events queued (count=2, dir=3).
REQ-032 Six distinct make/break pairs without pops -> count=4, key_out[8]=1, first four dirs preserved in order. One pop -> overflow=0, count=3.
REQ-033 Queue full; push and rd_en in the same cycle -> count stays 4, overflow stays 0, new event at tail.
REQ-034 Byte E0, then TIMEOUT_CYCLES idle, then 75 -> 75 treated as non-extended and ignored; count=0.
REQ-035 Byte 1D with PS2_WASD_EN -> key_out=10'h201. Without the macro -> count=0. rst mid-E0 prefix -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/ps2_move_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder_if : byte/strobe input and key-port output bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_move_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                  byte_in;
    logic                        byte_valid;
    logic                        rd_en;
    logic [9:0]                  key_out;
    logic [$clog2(FIFO_DEPTH):0] count;

    modport master (
        output byte_in, byte_valid, rd_en,
        input  key_out, count
    );

    modport slave (
        input  byte_in, byte_valid, rd_en,
        output key_out, count
    );
endinterface

`default_nettype wire

// File: rtl/ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder : PS/2 scan codes -> queued direction events (optional PS2_WASD_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ps2_move_decoder_if.slave  bus
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_ptr_w:0]   c_full     = FIFO_DEPTH[c_ptr_w:0];
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
`ifdef PS2_WASD_EN
    localparam int c_num_held = 9;
`else
    localparam int c_num_held = 5;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_tmo_w-1:0]      r_tmo;
    logic [c_num_held-1:0]   r_held;
    logic [2:0]              r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wptr;
    logic [c_ptr_w-1:0]      r_rptr;
    logic [c_ptr_w:0]        r_count;
    logic                    r_ovf;

    logic                    w_ext;
    logic                    w_hit;
    logic [2:0]              w_dir;
    logic [c_num_held-1:0]   w_mask;
    logic                    w_make;
    logic                    w_break;
    logic                    w_push;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_wr;

    // Prefix bytes E0/F0 never appear in either map, so no hit on them.
    assign w_ext = (r_state == EXT) || (r_state == EXT_BRK);

    always_comb begin
        w_hit  = 1'b0;
        w_dir  = 3'd0;
        w_mask = '0;
        if (w_ext) begin
            case (bus.byte_in)
                8'h75: begin w_hit = 1'b1; w_dir = 3'd1; w_mask[0] = 1'b1; end
                8'h72: begin w_hit = 1'b1; w_dir = 3'd2; w_mask[1] = 1'b1; end
                8'h6B: begin w_hit = 1'b1; w_dir = 3'd3; w_mask[2] = 1'b1; end
                8'h74: begin w_hit = 1'b1; w_dir = 3'd4; w_mask[3] = 1'b1; end
                default: ;
            endcase
        end else begin
            case (bus.byte_in)
                8'h5A,
                8'h2D: begin w_hit = 1'b1; w_dir = 3'd5; w_mask[4] = 1'b1; end
`ifdef PS2_WASD_EN
                8'h1D: begin w_hit = 1'b1; w_dir = 3'd1; w_mask[5] = 1'b1; end
                8'h1B: begin w_hit = 1'b1; w_dir = 3'd2; w_mask[6] = 1'b1; end
                8'h1C: begin w_hit = 1'b1; w_dir = 3'd3; w_mask[7] = 1'b1; end
                8'h23: begin w_hit = 1'b1; w_dir = 3'd4; w_mask[8] = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    assign w_make  = bus.byte_valid && w_hit && ((r_state == IDLE) || (r_state == EXT));
    assign w_break = bus.byte_valid && w_hit && ((r_state == BRK)  || (r_state == EXT_BRK));
    // Held bit set means the key is down: further makes are typematic repeats.
    assign w_push  = w_make && ((r_held & w_mask) == '0);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.byte_valid) begin
            case (r_state)
                IDLE: begin
                    if (bus.byte_in == 8'hE0)      w_state_nxt = EXT;
                    else if (bus.byte_in == 8'hF0) w_state_nxt = BRK;
                end
                EXT: begin
                    if (bus.byte_in == 8'hF0) w_state_nxt = EXT_BRK;
                    else                      w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if ((r_state != IDLE) && (r_tmo == c_tmo_last)) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.byte_valid || (r_state == IDLE)) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + 1'b1;
            if (w_push)       r_held <= r_held | w_mask;
            else if (w_break) r_held <= r_held & ~w_mask;
        end
    end

    // When full, a same-cycle pop frees the head slot that the push reuses.
    assign w_full = (r_count == c_full);
    assign w_pop  = bus.rd_en && (r_count != '0);
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_dir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop)                 r_ovf <= 1'b0;
            else if (w_push && w_full) r_ovf <= 1'b1;
        end
    end

    assign bus.count   = r_count;
    assign bus.key_out = {(r_count != '0), r_ovf, 5'b0,
                          (r_count != '0) ? r_mem[r_rptr] : 3'd0};

endmodule

`default_nettype wire
